// File: rtl/contador_crescente_tempo_pkg.sv
// Shared types and constants for the elapsed-time mm:ss up-counter.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package contador_crescente_tempo_pkg;

  // Control FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Highest value of each BCD digit
  localparam logic [3:0] BCD_MAX_UNI     = 4'd9;
  localparam logic [3:0] BCD_MAX_DEZ_SEG = 4'd5;

  // Four BCD digits of a mm:ss value, most significant first
  typedef struct packed {
    logic [3:0] dez_min;
    logic [3:0] uni_min;
    logic [3:0] dez_seg;
    logic [3:0] uni_seg;
  } tempo_t;

  // Largest representable time; the counter never wraps past this
  localparam tempo_t TEMPO_SAT  = '{dez_min: 4'd9, uni_min: 4'd9,
                                    dez_seg: 4'd5, uni_seg: 4'd9};
  localparam tempo_t TEMPO_ZERO = '0;

  // Value the digit chain will hold after one enabled increment.
  // Used to detect the limit on the same edge the digits move.
  function automatic tempo_t tempo_incr(input tempo_t t);
    tempo_t r;
    r = t;
    if (t.uni_seg == BCD_MAX_UNI) begin
      r.uni_seg = 4'd0;
      if (t.dez_seg == BCD_MAX_DEZ_SEG) begin
        r.dez_seg = 4'd0;
        if (t.uni_min == BCD_MAX_UNI) begin
          r.uni_min = 4'd0;
          r.dez_min = (t.dez_min == BCD_MAX_UNI) ? 4'd0 : t.dez_min + 4'd1;
        end else begin
          r.uni_min = t.uni_min + 4'd1;
        end
      end else begin
        r.dez_seg = t.dez_seg + 4'd1;
      end
    end else begin
      r.uni_seg = t.uni_seg + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_BCD_crescente.sv
// One BCD up-counting digit that wraps MAX -> 0 and reports a carry.
// Latency: digit updates on the enabling clock edge; carry is combinational.
// Backpressure: none; en advances the digit unconditionally.
module contador_BCD_crescente #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] bcd,
  output logic       carry
);

  // Carry feeds the enable of the next digit up in the same cycle
  assign carry = en & (bcd == MAX);

  // Digit register: clear beats increment
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd <= 4'd0;
    end else if (clr) begin
      bcd <= 4'd0;
    end else if (en) begin
      bcd <= (bcd == MAX) ? 4'd0 : bcd + 4'd1;
    end
  end

endmodule

// File: rtl/contador_crescente_tempo.sv
// Elapsed-time mm:ss BCD up-counter with latched limit; macro TICK_EXTERNO_EN swaps the prescaler for tick_in.
// Latency: digits, running and done all move on the edge that samples the tick; start/stop act in 1 cycle.
// Backpressure: none; start/stop are single-cycle pulses, clear is a level.
module contador_crescente_tempo
  import contador_crescente_tempo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef TICK_EXTERNO_EN
  input  logic       tick_in,
`endif
  input  logic [3:0] lim_dez_min,
  input  logic [3:0] lim_uni_min,
  input  logic [3:0] lim_dez_seg,
  input  logic [3:0] lim_uni_seg,
  output logic [3:0] uni_segundos,
  output logic [3:0] dez_segundos,
  output logic [3:0] uni_minutos,
  output logic [3:0] dez_minutos,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  state_t state_q;
  state_t state_n;
  tempo_t lim_q;
  tempo_t cnt;
  tempo_t cnt_inc;

  logic   tick;
  logic   latch_lim;
  logic   clr_cnt;
  logic   presc_clr;
  logic   presc_run;
  logic   count_en;
  logic   lim_zero;
  logic   sat;
  logic   done_pulse_q;

  logic   c_us;
  logic   c_ds;
  logic   c_um;
  logic   c_dm_unused;

`ifdef TICK_EXTERNO_EN
  // Shared 1 Hz source drives the count directly; prescaler controls go nowhere
  logic unused_presc;
  assign unused_presc = presc_clr | presc_run;
  assign tick         = tick_in;
`else
  localparam int             PW         = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] presc_q;

  // Prescaler: counts 0..CLK_FREQ_HZ-1 only while running, holds while paused
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (presc_clr) begin
      presc_q <= '0;
    end else if (presc_run) begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PRESC_LAST);
`endif

  // Current count gathered from the digit chain
  assign cnt.uni_seg = uni_segundos;
  assign cnt.dez_seg = dez_segundos;
  assign cnt.uni_min = uni_minutos;
  assign cnt.dez_min = dez_minutos;

  assign cnt_inc  = tempo_incr(cnt);
  assign lim_zero = (lim_q == TEMPO_ZERO);
  assign sat      = (cnt == TEMPO_SAT);

  // Next state and per-cycle controls; priority clear > stop > start > tick
  always_comb begin
    state_n   = state_q;
    latch_lim = 1'b0;
    clr_cnt   = 1'b0;
    presc_clr = 1'b0;
    presc_run = 1'b0;
    count_en  = 1'b0;
    if (clear) begin
      state_n   = ST_IDLE;
      clr_cnt   = 1'b1;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // stop alongside start cancels it here
          if (start && !stop) begin
            state_n   = ST_RUN;
            latch_lim = 1'b1;
            clr_cnt   = 1'b1;
            presc_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_n = ST_PAUSE;
          end else if (lim_zero) begin
            // A zero limit is met before any time elapses
            state_n = ST_DONE;
          end else begin
            presc_run = 1'b1;
            if (tick) begin
              if (sat) begin
                // 99:59 is held rather than wrapping to 00:00
                state_n = ST_DONE;
              end else begin
                count_en = 1'b1;
                if (cnt_inc == lim_q) begin
                  state_n = ST_DONE;
                end
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_n = ST_RUN;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State register and the done entry pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      done_pulse_q <= (state_n == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // Limit is captured only when a fresh run begins
  always_ff @(posedge clk) begin
    if (reset) begin
      lim_q <= TEMPO_ZERO;
    end else if (latch_lim) begin
      lim_q.dez_min <= lim_dez_min;
      lim_q.uni_min <= lim_uni_min;
      lim_q.dez_seg <= lim_dez_seg;
      lim_q.uni_seg <= lim_uni_seg;
    end
  end

  assign running    = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign done_pulse = done_pulse_q;

  // Ripple-enable digit chain: each digit steps when the one below wraps
  contador_BCD_crescente #(.MAX(BCD_MAX_UNI)) u_uni_seg (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .en    (count_en),
    .bcd   (uni_segundos),
    .carry (c_us)
  );

  contador_BCD_crescente #(.MAX(BCD_MAX_DEZ_SEG)) u_dez_seg (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .en    (c_us),
    .bcd   (dez_segundos),
    .carry (c_ds)
  );

  contador_BCD_crescente #(.MAX(BCD_MAX_UNI)) u_uni_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .en    (c_ds),
    .bcd   (uni_minutos),
    .carry (c_um)
  );

  contador_BCD_crescente #(.MAX(BCD_MAX_UNI)) u_dez_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .en    (c_um),
    .bcd   (dez_minutos),
    .carry (c_dm_unused)
  );

endmodule

// File: tb/tb_contador_crescente_tempo.sv
// Scoreboarded bench for the mm:ss up-counter with a 4-cycle prescaler.
// Latency: expectations carry a cycle offset relative to the previous check.
// Backpressure: none.
module tb_contador_crescente_tempo;

  localparam int FREQ = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] lim_dez_min;
  logic [3:0] lim_uni_min;
  logic [3:0] lim_dez_seg;
  logic [3:0] lim_uni_seg;
  logic [3:0] uni_segundos;
  logic [3:0] dez_segundos;
  logic [3:0] uni_minutos;
  logic [3:0] dez_minutos;
  logic       running;
  logic       done;
  logic       done_pulse;

  contador_crescente_tempo #(.CLK_FREQ_HZ(FREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .lim_dez_min  (lim_dez_min),
    .lim_uni_min  (lim_uni_min),
    .lim_dez_seg  (lim_dez_seg),
    .lim_uni_seg  (lim_uni_seg),
    .uni_segundos (uni_segundos),
    .dez_segundos (dez_segundos),
    .uni_minutos  (uni_minutos),
    .dez_minutos  (dez_minutos),
    .running      (running),
    .done         (done),
    .done_pulse   (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] val;
    int          wait_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Packs {done_pulse, done, running, mm:ss}
  function automatic logic [18:0] pk(input logic dp, input logic d, input logic r,
                                     input logic [15:0] t);
    return {dp, d, r, t};
  endfunction

  function automatic logic [18:0] observed();
    return {done_pulse, done, running, dez_minutos, uni_minutos, dez_segundos, uni_segundos};
  endfunction

  task automatic chk_val(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (dp,done,run,mmss)", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [18:0] val, input int wait_cyc);
    exp_t e;
    e.tag      = tag;
    e.val      = val;
    e.wait_cyc = wait_cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.wait_cyc);
      chk_val(e.tag, observed(), e.val);
    end
  endtask

  task automatic set_lim(input logic [15:0] t);
    lim_dez_min = t[15:12];
    lim_uni_min = t[11:8];
    lim_dez_seg = t[7:4];
    lim_uni_seg = t[3:0];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Steps until the digits read target or the budget runs out
  task automatic wait_count(input string tag, input logic [15:0] target, input int budget);
    logic [18:0] o;
    bit          hit;
    hit = 1'b0;
    o   = observed();
    for (int i = 0; i < budget && !hit; i++) begin
      step(1);
      o = observed();
      if (o[15:0] == target) hit = 1'b1;
    end
    chk_val(tag, {3'b000, o[15:0]}, {3'b000, target});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    set_lim(16'h0000);
    step(2);
    push_exp("reset_state", pk(0, 0, 0, 16'h0000), 0);
    drain();
    reset = 1'b0;

    // Reset mid-run at 00:07
    set_lim(16'h0009);
    pulse_start();
    push_exp("t1_run_0007", pk(0, 0, 1, 16'h0007), 28);
    drain();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_exp("t1_reset", pk(0, 0, 0, 16'h0000), 0);
    push_exp("t1_idle_hold", pk(0, 0, 0, 16'h0000), 8);
    drain();

    // Limit 00:03; mid-run limit change must be ignored
    set_lim(16'h0003);
    pulse_start();
    set_lim(16'h0001);
    push_exp("t2_start", pk(0, 0, 1, 16'h0000), 0);
    push_exp("t2_c3", pk(0, 0, 1, 16'h0000), 3);
    push_exp("t2_c4", pk(0, 0, 1, 16'h0001), 1);
    push_exp("t2_c8", pk(0, 0, 1, 16'h0002), 4);
    push_exp("t2_c11", pk(0, 0, 1, 16'h0002), 3);
    push_exp("t2_c12_done", pk(1, 1, 0, 16'h0003), 1);
    push_exp("t2_c13", pk(0, 1, 0, 16'h0003), 1);
    push_exp("t2_hold", pk(0, 1, 0, 16'h0003), 8);
    drain();

    // Zero limit restarted from DONE
    set_lim(16'h0000);
    pulse_start();
    push_exp("b_lim0_start", pk(0, 0, 1, 16'h0000), 0);
    push_exp("b_lim0_done", pk(1, 1, 0, 16'h0000), 1);
    push_exp("b_lim0_hold", pk(0, 1, 0, 16'h0000), 4);
    drain();

    // clear in DONE
    pulse_clear();
    push_exp("b_clear_done", pk(0, 0, 0, 16'h0000), 0);
    drain();

    // start with stop in IDLE is ignored
    set_lim(16'h0005);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    push_exp("b_ss_idle", pk(0, 0, 0, 16'h0000), 0);
    push_exp("b_ss_idle_hold", pk(0, 0, 0, 16'h0000), 4);
    drain();

    // Pause at 00:02 with prescaler at 2, resume
    pulse_start();
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    push_exp("t4_pause", pk(0, 0, 0, 16'h0002), 0);
    push_exp("t4_pause_hold", pk(0, 0, 0, 16'h0002), 20);
    drain();
    pulse_start();
    push_exp("t4_resume", pk(0, 0, 1, 16'h0002), 0);
    push_exp("t4_resume_1", pk(0, 0, 1, 16'h0002), 1);
    push_exp("t4_resume_2", pk(0, 0, 1, 16'h0003), 1);
    drain();
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    push_exp("t4_ss_pause", pk(0, 0, 0, 16'h0003), 0);
    push_exp("t4_ss_hold", pk(0, 0, 0, 16'h0003), 8);
    drain();
    pulse_start();
    push_exp("t4_res2", pk(0, 0, 1, 16'h0003), 0);
    push_exp("t4_res2_3", pk(0, 0, 1, 16'h0003), 3);
    push_exp("t4_0004", pk(0, 0, 1, 16'h0004), 1);
    push_exp("t4_0005_done", pk(1, 1, 0, 16'h0005), 4);
    drain();

    // Carry chain toward limit 10:00
    pulse_clear();
    set_lim(16'h1000);
    pulse_start();
    wait_count("t3_reach_0958", 16'h0958, 3000);
    push_exp("t3_0959", pk(0, 0, 1, 16'h0959), 4);
    push_exp("t3_1000_done", pk(1, 1, 0, 16'h1000), 4);
    drain();

    // Saturation with limit 99:59
    pulse_clear();
    set_lim(16'h9959);
    pulse_start();
    wait_count("t5_reach_9958", 16'h9958, 25000);
    push_exp("t5_9959_done", pk(1, 1, 0, 16'h9959), 4);
    push_exp("t5_hold", pk(0, 1, 0, 16'h9959), 12);
    drain();

    // Saturation with an invalid limit digit
    pulse_clear();
    set_lim(16'hA000);
    pulse_start();
    wait_count("t5b_reach_9959", 16'h9959, 25000);
    push_exp("t5b_still_run", pk(0, 0, 1, 16'h9959), 0);
    push_exp("t5b_sat_done", pk(1, 1, 0, 16'h9959), 4);
    push_exp("t5b_hold", pk(0, 1, 0, 16'h9959), 12);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
